mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Parametrised multicycle integer multiply/divide unit for the multicycle CPU datapath (MIPS mult/multu/div/divu).
- Takes operands from the A/B registers. Iterates one bit per cycle. Writes a 2×WIDTH result into internal HI/LO registers.
- Generalised in operand width and signedness mode.
- The control unit stalls on busy and advances on done.

Parameters:
- WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits. Legal range 4..64.
- CNT_W, $clog2(WIDTH)+1, iteration counter width. Derived; do not override.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset. Name kept as in the codebase; asserted when 0.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  1  0 = multiply, 1 = divide.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- a  in  WIDTH  multiplicand / dividend.
- b  in  WIDTH  multiplier / divisor.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  high with done when a divide had b==0; otherwise 0.
- hi  out  WIDTH  mult: upper product half; div: remainder.
- lo  out  WIDTH  mult: lower product half; div: quotient.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; busy, done, div_zero, hi, lo, counter and internal operands all 0. Applies mid-operation: the operation is aborted and no done is ever produced for it.
- FSM states: IDLE, INIT, RUN, FIX, DONE.
- IDLE:
  - start==1 → INIT; latch op, is_signed, a, b.
  - Otherwise stay in IDLE.
- INIT (1 cycle):
  - Form magnitudes |a|, |b| when is_signed, else raw values.
  - Record result sign: mult = sa^sb; div quotient = sa^sb, remainder = sa.
  - Clear accumulators; counter=WIDTH.
  - If op==1 and b==0 → DONE directly. Otherwise → RUN.
- RUN (exactly WIDTH cycles):
  - Mult: shift-add, one multiplier bit per cycle, into a 2×WIDTH accumulator.
  - Div: restoring division, one quotient bit per cycle.
  - Counter decrements each cycle; at counter==1 → FIX.
- FIX (1 cycle):
  - Apply two's-complement negation per the recorded signs.
  - Mult: negate the full 2×WIDTH product.
  - Div: negate quotient and remainder independently.
  - → DONE.
- DONE (1 cycle):
  - done=1; hi/lo updated on the edge entering DONE.
  - div_zero=1 only for the divide-by-zero path; hi and lo are left unchanged on that path.
  - → IDLE.
- busy: 1 in INIT, RUN, FIX; 0 in IDLE and DONE.
- Latency:
  - Normal operation: done is high in the cycle starting WIDTH+3 rising edges after the edge that sampled start (35 for WIDTH=32).
  - Divide by zero: 2 edges.
- Arithmetic:
  - Signed division truncates toward zero; remainder takes the sign of the dividend.
  - Signed MIN / -1 gives lo=MIN, hi=0 (wraps, no flag).
  - Unsigned mode never negates.
- start asserted while busy or in DONE: ignored, not queued.
- start asserted in IDLE on the cycle after DONE: accepted normally (back-to-back).
- Inputs a, b, op, is_signed may change after the start edge without affecting the result.
- hi and lo hold their last result indefinitely, including across ignored starts.

Test Plan (WIDTH=32):
1. Signed mult a=0xFFFFFFFD (-3), b=7 → done at edge 35; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high edges 1..34.
2. Unsigned mult a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. The same operands with is_signed=1 → hi=0, lo=1.
3. Signed div a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Unsigned div 100/7 → lo=14, hi=2. Signed 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
4. Divide by zero with a=5, b=0, prior hi=0x11, lo=0x22 → done and div_zero high at edge 2; hi=0x11, lo=0x22 unchanged. div_zero=0 on the next normal operation.
5. Start a mult, re-pulse start with new operands at edge 10 → ignored; a single done at edge 35 with the first result. A new start the cycle after done is accepted.
6. Assert reset=0 at edge 20 of a divide → busy, done, hi, lo = 0 immediately; no done afterwards. Release reset and run 6*7 unsigned → lo=42, hi=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Multicycle integer multiply/divide unit for the multicycle CPU datapath
// (mult/multu/div/divu). One result bit is produced per clock: shift-add for
// multiply, restoring division for divide. The 2*WIDTH result lands in the
// HI/LO registers exposed on hi/lo.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   request pulse, only honoured while the FSM is idle
//   op         in   0 = multiply, 1 = divide
//   is_signed  in   1 = two's-complement operands, 0 = unsigned
//   a          in   multiplicand / dividend
//   b          in   multiplier / divisor
//   busy       out  operation in progress (control unit stalls on it)
//   done       out  one-cycle completion pulse
//   div_zero   out  set together with done when a divide had b == 0
//   hi         out  mult: upper product half, div: remainder
//   lo         out  mult: lower product half, div: quotient
//
// Output timing: busy/done/div_zero/hi/lo are registered from the current
// FSM state, so they trail the state register by one clock. For a start
// sampled at edge 0 this gives busy high after edges 1..WIDTH+2 and done
// after edge WIDTH+3; a divide by zero shows done after edge 2.
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t               state_q;
  logic                 op_q;        // latched operation
  logic                 sgn_q;       // latched signedness
  logic [WIDTH-1:0]     a_q;         // latched raw operand a
  logic [WIDTH-1:0]     b_q;         // latched raw operand b
  logic [WIDTH-1:0]     mag_q;       // multiplicand (mult) or divisor (div) magnitude
  logic [2*WIDTH-1:0]   acc_q;       // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [CNT_W-1:0]     cnt_q;       // remaining iterations
  logic                 neg_lo_q;    // negate product (mult) or quotient (div)
  logic                 neg_hi_q;    // negate remainder (div only)
  logic                 dz_q;        // current divide has a zero divisor
  logic                 busy_q;
  logic                 done_q;
  logic                 div_zero_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic [WIDTH:0]       mul_sum_d;
  logic [2*WIDTH-1:0]   acc_mul_d;
  logic [WIDTH:0]       div_shift_d;
  logic [WIDTH:0]       div_trial_d;
  logic [2*WIDTH-1:0]   acc_div_d;

  // Two's-complement negation of a WIDTH-bit value.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    neg_w = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Two's-complement negation of a full 2*WIDTH-bit product.
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    neg_2w = (~v) + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of an operand; unsigned mode passes the raw value through.
  // The most negative value maps to 2^(WIDTH-1), which is correct as an
  // unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v,
                                              input logic             sgn);
    if (sgn && v[WIDTH-1]) begin
      mag_of = neg_w(v);
    end else begin
      mag_of = v;
    end
  endfunction

  // One iteration of shift-add multiply and of restoring division.
  always_comb begin
    mul_sum_d   = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    acc_mul_d   = acc_q;
    div_shift_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial_d = div_shift_d - {1'b0, mag_q};
    acc_div_d   = acc_q;

    // Multiply: add the multiplicand when the current multiplier bit is set,
    // then shift the whole accumulator right; the carry becomes the new MSB.
    if (acc_q[0]) begin
      mul_sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_q};
    end else begin
      mul_sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    end
    acc_mul_d = {mul_sum_d, acc_q[WIDTH-1:1]};

    // Divide: shift the next dividend bit into the remainder and keep the
    // trial difference only when it did not go negative.
    if (!div_trial_d[WIDTH]) begin
      acc_div_d = {div_trial_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_div_d = {div_shift_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      op_q       <= 1'b0;
      sgn_q      <= 1'b0;
      a_q        <= {WIDTH{1'b0}};
      b_q        <= {WIDTH{1'b0}};
      mag_q      <= {WIDTH{1'b0}};
      acc_q      <= {(2*WIDTH){1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
    end else begin
      // Outputs follow the state the FSM is leaving on this edge.
      busy_q     <= (state_q == ST_INIT) || (state_q == ST_RUN) || (state_q == ST_FIX);
      done_q     <= (state_q == ST_DONE);
      div_zero_q <= (state_q == ST_DONE) && dz_q;
      if ((state_q == ST_DONE) && !dz_q) begin
        hi_q <= acc_q[2*WIDTH-1:WIDTH];
        lo_q <= acc_q[WIDTH-1:0];
      end else begin
        hi_q <= hi_q;
        lo_q <= lo_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op;
            sgn_q   <= is_signed;
            a_q     <= a;
            b_q     <= b;
            state_q <= ST_INIT;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_INIT: begin
          // mag_q holds the operand that is added/subtracted every cycle;
          // the other operand is shifted through the low half of acc_q.
          if (op_q) begin
            mag_q <= mag_of(b_q, sgn_q);
            acc_q <= {{WIDTH{1'b0}}, mag_of(a_q, sgn_q)};
          end else begin
            mag_q <= mag_of(a_q, sgn_q);
            acc_q <= {{WIDTH{1'b0}}, mag_of(b_q, sgn_q)};
          end
          neg_lo_q <= sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_hi_q <= sgn_q && a_q[WIDTH-1];
          cnt_q    <= CNT_W'(WIDTH);
          if (op_q && (b_q == {WIDTH{1'b0}})) begin
            dz_q    <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            dz_q    <= 1'b0;
            state_q <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (op_q) begin
            acc_q <= acc_div_d;
          end else begin
            acc_q <= acc_mul_d;
          end
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_FIX;
          end else begin
            state_q <= ST_RUN;
          end
        end

        ST_FIX: begin
          if (op_q) begin
            // Quotient and remainder carry independent signs.
            if (neg_hi_q) begin
              acc_q[2*WIDTH-1:WIDTH] <= neg_w(acc_q[2*WIDTH-1:WIDTH]);
            end else begin
              acc_q[2*WIDTH-1:WIDTH] <= acc_q[2*WIDTH-1:WIDTH];
            end
            if (neg_lo_q) begin
              acc_q[WIDTH-1:0] <= neg_w(acc_q[WIDTH-1:0]);
            end else begin
              acc_q[WIDTH-1:0] <= acc_q[WIDTH-1:0];
            end
          end else begin
            if (neg_lo_q) begin
              acc_q <= neg_2w(acc_q);
            end else begin
              acc_q <= acc_q;
            end
          end
          state_q <= ST_DONE;
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//
// Directed table of multiply/divide vectors with hand-computed results and
// latencies, plus hand-written sequences for ignored starts, back-to-back
// operation and reset in the middle of an operation. WIDTH = 32.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic         op;
  logic         is_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks;
  int failures;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         op;
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    logic         exp_dz;
    int           exp_lat;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Pulse start for one sampling edge (edge 0), scramble the inputs after
  // that edge, then wait up to 100 edges for done. lat=0 means no done.
  task automatic run_op(input logic op_v, input logic sgn_v,
                        input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                        output int lat, output logic [W-1:0] hi_v,
                        output logic [W-1:0] lo_v, output logic dz_v,
                        output int busy_bad);
    op        = op_v;
    is_signed = sgn_v;
    a         = a_v;
    b         = b_v;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    op        = ~op_v;
    is_signed = ~sgn_v;
    a         = $urandom;
    b         = $urandom;
    lat       = 0;
    busy_bad  = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = k;
        if (busy !== 1'b0) busy_bad++;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
    end
    hi_v = hi;
    lo_v = lo;
    dz_v = div_zero;
  endtask

  initial begin
    int           lat;
    int           busy_bad;
    int           done_cnt;
    int           done_edge;
    logic [W-1:0] hi_v;
    logic [W-1:0] lo_v;
    logic         dz_v;

    checks   = 0;
    failures = 0;

    //           op    sgn   a             b             hi            lo            dz    lat
    vecs[0]  = '{1'b0, 1'b1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 35};
    vecs[1]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 35};
    vecs[2]  = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 35};
    vecs[3]  = '{1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 35};
    vecs[4]  = '{1'b1, 1'b0, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 35};
    vecs[5]  = '{1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 35};
    vecs[6]  = '{1'b0, 1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 35};
    vecs[7]  = '{1'b1, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 35};
    vecs[8]  = '{1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 1'b0, 35};
    vecs[9]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 35};
    vecs[10] = '{1'b1, 1'b0, 32'h00002211, 32'h00000100, 32'h00000011, 32'h00000022, 1'b0, 35};
    vecs[11] = '{1'b1, 1'b1, 32'h00000005, 32'h00000000, 32'h00000011, 32'h00000022, 1'b1, 2};
    vecs[12] = '{1'b0, 1'b0, 32'd6,        32'd7,        32'd0,        32'd42,       1'b0, 35};

    reset     = 1'b0;
    start     = 1'b0;
    op        = 1'b0;
    is_signed = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy",     {63'd0, busy},     64'd0);
    chk("reset_done",     {63'd0, done},     64'd0);
    chk("reset_div_zero", {63'd0, div_zero}, 64'd0);
    chk("reset_hi",       {32'd0, hi},       64'd0);
    chk("reset_lo",       {32'd0, lo},       64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven vectors, each followed by a check that done lasts one cycle.
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, lat, hi_v, lo_v, dz_v, busy_bad);
      chk($sformatf("v%0d_latency", i),  64'(lat),           64'(vecs[i].exp_lat));
      chk($sformatf("v%0d_hi", i),       {32'd0, hi_v},      {32'd0, vecs[i].exp_hi});
      chk($sformatf("v%0d_lo", i),       {32'd0, lo_v},      {32'd0, vecs[i].exp_lo});
      chk($sformatf("v%0d_div_zero", i), {63'd0, dz_v},      {63'd0, vecs[i].exp_dz});
      chk($sformatf("v%0d_busy_bad", i), 64'(busy_bad),      64'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), {63'd0, done},    64'd0);
    end

    // Ignored re-start while busy: 3*5 unsigned, new start at edge 10.
    op        = 1'b0;
    is_signed = 1'b0;
    a         = 32'd3;
    b         = 32'd5;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    done_cnt  = 0;
    done_edge = 0;
    for (int k = 1; k <= 35; k++) begin
      if (k == 10) begin
        start     = 1'b1;
        op        = 1'b1;
        a         = 32'd100;
        b         = 32'd7;
      end else begin
        start     = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        done_cnt++;
        done_edge = k;
      end
    end
    start = 1'b0;
    chk("ign_done_edge", 64'(done_edge), 64'd35);
    chk("ign_hi",        {32'd0, hi},    64'd0);
    chk("ign_lo",        {32'd0, lo},    64'd15);

    // Back-to-back: start raised in the cycle done is visible.
    run_op(1'b0, 1'b0, 32'd9, 32'd9, lat, hi_v, lo_v, dz_v, busy_bad);
    chk("b2b_latency", 64'(lat),      64'd35);
    chk("b2b_lo",      {32'd0, lo_v}, 64'd81);
    // No stray done from the ignored divide request anywhere before this.
    chk("ign_done_count", 64'(done_cnt), 64'd1);

    // Reset at edge 20 of a divide.
    op        = 1'b1;
    is_signed = 1'b0;
    a         = 32'd100;
    b         = 32'd7;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_done", {63'd0, done}, 64'd0);
    chk("rst_mid_hi",   {32'd0, hi},   64'd0);
    chk("rst_mid_lo",   {32'd0, lo},   64'd0);
    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_cnt++;
    end
    chk("rst_no_done", 64'(done_cnt), 64'd0);
    run_op(1'b0, 1'b0, 32'd6, 32'd7, lat, hi_v, lo_v, dz_v, busy_bad);
    chk("rst_after_latency", 64'(lat),      64'd35);
    chk("rst_after_hi",      {32'd0, hi_v}, 64'd0);
    chk("rst_after_lo",      {32'd0, lo_v}, 64'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
